// File: rtl/mdu_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
package mdu_pkg;

  localparam int unsigned MDU_XLEN = 32;

  localparam logic [MDU_XLEN-1:0] MDU_DIV0_QUOT    = {MDU_XLEN{1'b1}};
  localparam logic [MDU_XLEN-1:0] MDU_OVF_DIVIDEND = {1'b1, {(MDU_XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } mdu_state_t;

  function automatic logic op_is_div(input mdu_op_t op);
    return op[2];
  endfunction

  function automatic logic op_is_rem(input mdu_op_t op);
    return op[2] & op[1];
  endfunction

  // MUL is handled as unsigned: its low word does not depend on operand signs.
  function automatic logic op_signed_a(input mdu_op_t op);
    logic res;
    case (op)
      MULH, MULHSU, DIV, REM: res = 1'b1;
      default:                res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic op_signed_b(input mdu_op_t op);
    logic res;
    case (op)
      MULH, DIV, REM: res = 1'b1;
      default:        res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
module mdu_iter_step
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN:0] acc_i,
  input  logic [XLEN-1:0] operand_i,
  input  logic            is_div_i,
  output logic [2*XLEN:0] acc_o
);

  logic [XLEN:0]   add_sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN+1:0] diff;

  // acc = {hi+carry, lo}; multiply consumes lo LSB-first, divide shifts quotient bits into lo
  always_comb begin
    add_sum = acc_i[2*XLEN:XLEN]
            + (acc_i[0] ? {1'b0, operand_i} : {(XLEN+1){1'b0}});
    rem_sh  = acc_i[2*XLEN-1:XLEN-1];
    diff    = {1'b0, rem_sh} - {2'b00, operand_i};
    if (is_div_i) begin
      acc_o = {(diff[XLEN+1] ? rem_sh : diff[XLEN:0]), acc_i[XLEN-2:0], ~diff[XLEN+1]};
    end else begin
      acc_o = {1'b0, add_sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle RV32M multiply/divide sequencer: operands are run as magnitudes
// through XLEN iterations and sign-corrected in a final fix-up cycle.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int XLEN  = MDU_XLEN,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] Result
);

  localparam int               AW        = 2 * XLEN + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

  mdu_state_t        state_q, state_d;
  mdu_op_t           op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic              neg_q, neg_d;
  logic              special_q, special_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;

  mdu_op_t           req_op;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   special_val;
  logic [AW-1:0]     acc_step;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quot, rem;
  logic [XLEN-1:0]   fix_val;

  mdu_iter_step #(.XLEN(XLEN)) u_step (
    .acc_i     (acc_q),
    .operand_i (opnd_q),
    .is_div_i  (op_is_div(op_q)),
    .acc_o     (acc_step)
  );

  // Request decode: magnitudes, sign flags and the results of the divide special cases
  always_comb begin
    req_op   = mdu_op_t'(Funct3);
    a_neg    = op_signed_a(req_op) & SrcA[XLEN-1];
    b_neg    = op_signed_b(req_op) & SrcB[XLEN-1];
    a_mag    = a_neg ? (-SrcA) : SrcA;
    b_mag    = b_neg ? (-SrcB) : SrcB;
    div_zero = op_is_div(req_op) && (SrcB == {XLEN{1'b0}});
    div_ovf  = op_is_div(req_op) && op_signed_a(req_op)
               && (SrcA == MDU_OVF_DIVIDEND) && (SrcB == {XLEN{1'b1}});
    if (div_zero) begin
      special_val = op_is_rem(req_op) ? SrcA : MDU_DIV0_QUOT;
    end else if (op_is_rem(req_op)) begin
      special_val = {XLEN{1'b0}};
    end else begin
      special_val = MDU_OVF_DIVIDEND;
    end
  end

  // Fix-up: a signed product is negated across the full double word before the word select
  always_comb begin
    prod     = acc_q[2*XLEN-1:0];
    prod_fix = neg_q ? (-prod) : prod;
    quot     = acc_q[XLEN-1:0];
    rem      = acc_q[2*XLEN-1:XLEN];
    if (special_q) begin
      fix_val = acc_q[XLEN-1:0];
    end else begin
      case (op_q)
        MUL:                fix_val = prod_fix[XLEN-1:0];
        MULH, MULHSU, MULHU: fix_val = prod_fix[2*XLEN-1:XLEN];
        DIV, DIVU:          fix_val = neg_q ? (-quot) : quot;
        REM, REMU:          fix_val = neg_q ? (-rem) : rem;
        default:            fix_val = {XLEN{1'b0}};
      endcase
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    neg_d     = neg_q;
    special_d = special_q;
    result_d  = result_q;
    case (state_q)
      IDLE: begin
        if (start && !kill) begin
          op_d = req_op;
          if (op_is_div(req_op)) begin
            neg_d  = op_is_rem(req_op) ? a_neg : (a_neg ^ b_neg);
            opnd_d = b_mag;
          end else begin
            neg_d  = a_neg ^ b_neg;
            opnd_d = a_mag;
          end
          if (div_zero || div_ovf) begin
            special_d = 1'b1;
            acc_d     = {{(XLEN+1){1'b0}}, special_val};
            state_d   = FIX;
          end else begin
            special_d = 1'b0;
            acc_d     = {{(XLEN+1){1'b0}}, (op_is_div(req_op) ? a_mag : b_mag)};
            cnt_d     = {CNT_W{1'b0}};
            state_d   = CALC;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (kill) begin
          state_d = IDLE;
        end else begin
          acc_d = acc_step;
          if (cnt_q == LAST_ITER) begin
            state_d = FIX;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      FIX: begin
        if (kill) begin
          state_d = IDLE;
        end else begin
          result_d = fix_val;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= MUL;
      cnt_q     <= {CNT_W{1'b0}};
      acc_q     <= {AW{1'b0}};
      opnd_q    <= {XLEN{1'b0}};
      neg_q     <= 1'b0;
      special_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= {XLEN{1'b0}};
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      neg_q     <= neg_d;
      special_q <= special_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign Result = result_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed and random checks of mdu_sequencer against a scoreboard of expected results.
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        kill;
  logic [2:0]  Funct3;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        busy;
  logic        done;
  logic [31:0] Result;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic [31:0] sb_q[$];

  mdu_sequencer dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .kill   (kill),
    .Funct3 (Funct3),
    .SrcA   (SrcA),
    .SrcB   (SrcB),
    .busy   (busy),
    .done   (done),
    .Result (Result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  initial begin
    #400000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model built on native 64-bit multiply and SV division
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (f)
      3'd0: p = {32'd0, a} * {32'd0, b};
      3'd1: p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      3'd2: p = {{32{a[31]}}, a} * {32'd0, b};
      3'd3: p = {32'd0, a} * {32'd0, b};
      default: p = 64'd0;
    endcase
    case (f)
      3'd0: return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4: return (b == 32'd0) ? 32'hFFFF_FFFF :
                   ((a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(sa / sb));
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 32'd0) ? a :
                   ((a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb));
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input bit hold);
    int t0;
    bit seen;
    @(negedge clk);
    Funct3 = f;
    SrcA   = a;
    SrcB   = b;
    start  = 1'b1;
    sb_q.push_back(exp);
    t0   = cyc;
    seen = 1'b0;
    for (int n = 1; n <= 60 && !seen; n++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      SrcA   = $urandom;
      SrcB   = $urandom;
      Funct3 = 3'($urandom);
      if (n == 1) check("busy_after_start", {31'd0, busy}, 32'd1);
      if (done === 1'b1) begin
        seen = 1'b1;
        check("result", Result, sb_q.pop_front());
        check("latency", 32'(cyc - t0), 32'(lat));
      end
    end
    start = 1'b0;
    if (!seen) begin
      check("done_timeout", 32'd0, 32'd1);
      void'(sb_q.pop_front());
    end else begin
      @(negedge clk);
      check("idle_after_done", {30'd0, busy, done}, 32'd0);
    end
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    int          lat, t0, dc;
    rst_n  = 1'b0;
    start  = 1'b0;
    kill   = 1'b0;
    Funct3 = 3'd0;
    SrcA   = 32'd0;
    SrcB   = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {busy, done} == 2'b00 ? Result : 32'hDEAD_BEEF, 32'd0);
    rst_n = 1'b1;

    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 1'b1);
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 1'b0);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 1'b0);
    do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 34, 1'b0);
    do_op(3'd4, 32'h1234, 32'd0, 32'hFFFF_FFFF, 2, 1'b0);
    do_op(3'd6, 32'h1234, 32'd0, 32'h1234, 2, 1'b0);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 1'b0);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2, 1'b0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 1'b0);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 1'b0);
    do_op(3'd5, 32'd100, 32'd7, 32'd14, 34, 1'b0);
    do_op(3'd7, 32'd100, 32'd7, 32'd2, 34, 1'b0);

    // kill wins over start while idle
    @(negedge clk);
    Funct3 = 3'd5; SrcA = 32'd50; SrcB = 32'd5; start = 1'b1; kill = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    check("kill_over_start", {31'd0, busy}, 32'd0);

    // kill at cycle 10 of a DIVU
    @(negedge clk);
    Funct3 = 3'd5; SrcA = 32'd1000; SrcB = 32'd3; start = 1'b1;
    t0 = cyc;
    dc = done_cnt;
    @(negedge clk);
    start = 1'b0;
    while (cyc < t0 + 10) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_busy_drop", {31'd0, busy}, 32'd0);
    repeat (40) @(negedge clk);
    check("kill_no_done", 32'(done_cnt - dc), 32'd0);
    check("kill_result_held", Result, 32'd2);

    // asynchronous reset in the middle of a MUL
    @(negedge clk);
    Funct3 = 3'd0; SrcA = 32'd5; SrcB = 32'd6; start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc < t0 + 5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_busy", {31'd0, busy}, 32'd0);
    check("async_reset_result", Result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(3'd0, 32'd3, 32'd4, 32'd12, 34, 1'b0);

    for (int k = 0; k < 10; k++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      if (k == 3) b = 32'd0;
      if (k == 5) begin
        f = 3'd4;
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      if (k == 7) b = 32'($urandom_range(1, 15));
      lat = (f[2] && (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 2 : 34;
      do_op(f, a, b, model(f, a, b), lat, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
